// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter that lets three requesters share one LCD writer.
// The granted screen image is snapshotted and held while the writer runs.
module lcd_msg_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic [2:0]   req,
  input  logic [255:0] data0,
  input  logic [255:0] data1,
  input  logic [255:0] data2,
  output logic [2:0]   grant,
  output logic [2:0]   done,
  output logic         busy,
  output logic [255:0] lcd_data,
  output logic         lcd_write,
  input  logic         lcd_ready
);

  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    DONE
  } stateT;

  stateT              stateReg, stateNext;
  logic [2:0]         grantReg, grantNext;
  logic [1:0]         lastReg, lastNext;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic [255:0]       dataReg, dataNext;

  logic [1:0]         order0, order1, order2;
  logic [1:0]         pickIdx;
  logic               pickValid;

  // Search order starts just after the last served requester.
  always_comb begin
    order0 = 2'd0;
    order1 = 2'd1;
    order2 = 2'd2;
    case (lastReg)
      2'd0: begin order0 = 2'd1; order1 = 2'd2; order2 = 2'd0; end
      2'd1: begin order0 = 2'd2; order1 = 2'd0; order2 = 2'd1; end
      default: begin order0 = 2'd0; order1 = 2'd1; order2 = 2'd2; end
    endcase
    pickValid = |req;
    if (req[order0])      pickIdx = order0;
    else if (req[order1]) pickIdx = order1;
    else                  pickIdx = order2;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateReg <= IDLE;
      grantReg <= '0;
      lastReg  <= 2'd2;
      cntReg   <= '0;
      dataReg  <= '0;
    end else begin
      stateReg <= stateNext;
      grantReg <= grantNext;
      lastReg  <= lastNext;
      cntReg   <= cntNext;
      dataReg  <= dataNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    grantNext = grantReg;
    lastNext  = lastReg;
    cntNext   = cntReg;
    dataNext  = dataReg;
    lcd_write = 1'b0;
    done      = '0;
    busy      = (stateReg != IDLE);
    case (stateReg)
      IDLE: begin
        if (lcd_ready && pickValid) begin
          stateNext = ISSUE;
          grantNext = 3'b001 << pickIdx;
          dataNext  = (pickIdx == 2'd0) ? data0 :
                      (pickIdx == 2'd1) ? data1 : data2;
        end
      end
      ISSUE: begin
        lcd_write = 1'b1;
        cntNext   = '0;
        stateNext = WAIT_START;
      end
      WAIT_START: begin
        // A writer that never drops ready missed the pulse; re-issue it.
        if (!lcd_ready)
          stateNext = WAIT_DONE;
        else if (cntReg == CNT_W'(START_TIMEOUT - 1))
          stateNext = ISSUE;
        else
          cntNext = cntReg + 1'b1;
      end
      WAIT_DONE: begin
        if (lcd_ready)
          stateNext = DONE;
      end
      DONE: begin
        done      = grantReg;
        grantNext = '0;
        lastNext  = grantReg[1] ? 2'd1 : (grantReg[2] ? 2'd2 : 2'd0);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign grant    = grantReg;
  assign lcd_data = dataReg;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Randomized bench for lcd_msg_arbiter: a transaction-level model predicts
// each grant, the held snapshot, write pulses, retries and done pulses.
module tb_lcd_msg_arbiter;

  logic         iCLK = 1'b0;
  logic         iRST_N;
  logic [2:0]   req;
  logic [255:0] data0, data1, data2;
  logic [2:0]   grant, done;
  logic         busy;
  logic [255:0] lcd_data;
  logic         lcd_write;
  logic         lcdReady;

  int nCompared = 0;
  int nMismatch = 0;
  int lastM     = 2;

  lcd_msg_arbiter #(.START_TIMEOUT(16)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .lcd_data  (lcd_data),
    .lcd_write (lcd_write),
    .lcd_ready (lcdReady)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic randData();
    for (int i = 0; i < 8; i++) begin
      data0[i*32 +: 32] = $urandom();
      data1[i*32 +: 32] = $urandom();
      data2[i*32 +: 32] = $urandom();
    end
  endtask

  // Next requester after 'last' (mod 3) whose request is high.
  function automatic int rrPick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic serve(input logic [2:0] reqFinal, input int blockN, input int ignoreN,
                       input int delayD, input int busyN, input bit dropReq, input bit scramble);
    int g;
    logic [2:0] gOh;
    logic [255:0] snap;
    for (int i = 0; i < blockN; i++) begin
      lcdReady = 1'b0;
      req = 3'($urandom_range(0, 7));
      if (scramble) randData();
      step();
      checkVal("blocked_grant", grant, 0);
      checkVal("blocked_busy", busy, 0);
    end
    lcdReady = 1'b1;
    req = reqFinal;
    if (scramble) randData();
    g = rrPick(lastM, reqFinal);
    gOh = 3'b001 << g;
    snap = (g == 0) ? data0 : (g == 1) ? data1 : data2;
    step();
    checkVal("grant", grant, gOh);
    checkVal("first_write", lcd_write, 1);
    checkVal("snapshot", lcd_data, snap);
    checkVal("busy_on_grant", busy, 1);
    if (dropReq) req = 3'b000;
    for (int n = 0; n < ignoreN; n++) begin
      for (int i = 0; i < 16; i++) begin
        if (scramble) randData();
        step();
        checkVal("retry_quiet", lcd_write, 0);
      end
      if (scramble) randData();
      step();
      checkVal("retry_write", lcd_write, 1);
      checkVal("retry_grant", grant, gOh);
    end
    for (int i = 0; i < delayD; i++) begin
      if (scramble) randData();
      step();
      checkVal("start_quiet", lcd_write, 0);
    end
    lcdReady = 1'b0;
    for (int i = 0; i < busyN; i++) begin
      if (scramble) randData();
      step();
      checkVal("busy_done", done, 0);
      checkVal("busy_busy", busy, 1);
    end
    lcdReady = 1'b1;
    step();
    checkVal("done_pulse", done, gOh);
    checkVal("done_data", lcd_data, snap);
    step();
    checkVal("done_clear", done, 0);
    checkVal("grant_clear", grant, 0);
    checkVal("idle_busy", busy, 0);
    lastM = g;
    $display("serve req=%b grant=%b retries=%0d delay=%0d writer=%0d drop=%0d",
             reqFinal, gOh, ignoreN, delayD, busyN, dropReq);
  endtask

  initial begin
    int g;
    iRST_N = 1'b0;
    req = 3'b000;
    lcdReady = 1'b1;
    data0 = '0;
    data1 = '0;
    data2 = '0;
    repeat (3) @(posedge iCLK);
    #1;
    checkVal("rst_grant", grant, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_write", lcd_write, 0);
    checkVal("rst_data", lcd_data, 0);
    iRST_N = 1'b1;
    step();
    checkVal("idle_no_req", grant, 0);

    // Contention from reset: requester 0 first, then wrap around.
    for (int i = 0; i < 4; i++) serve(3'b111, 0, 0, 2, 8, 1'b0, 1'b1);
    data0 = {"HELLO WORLD 1234", "SECOND LINE TEXT"};
    serve(3'b001, 0, 0, 0, 100, 1'b0, 1'b0);
    serve(3'b010, 0, 1, 4, 6, 1'b0, 1'b1);
    serve(3'b010, 4, 0, 1, 3, 1'b0, 1'b1);
    serve(3'b101, 1, 0, 2, 3, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      serve(3'($urandom_range(1, 7)), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 12),
            $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset during WAIT_DONE.
    req = 3'b011;
    lcdReady = 1'b1;
    g = rrPick(lastM, 3'b011);
    step();
    checkVal("rst_pre_grant", grant, 3'b001 << g);
    step();
    lcdReady = 1'b0;
    step();
    step();
    #2;
    iRST_N = 1'b0;
    #1;
    checkVal("rst_mid_grant", grant, 0);
    checkVal("rst_mid_busy", busy, 0);
    checkVal("rst_mid_write", lcd_write, 0);
    checkVal("rst_mid_data", lcd_data, 0);
    req = 3'b100;
    lcdReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checkVal("rst_hold_done", done, 0);
      checkVal("rst_hold_grant", grant, 0);
    end
    iRST_N = 1'b1;
    lastM = 2;
    step();
    checkVal("post_rst_grant", grant, 3'b100);
    checkVal("post_rst_write", lcd_write, 1);

    // Reset during ISSUE drops the write pulse at once.
    iRST_N = 1'b0;
    #1;
    checkVal("rst_issue_write", lcd_write, 0);
    checkVal("rst_issue_grant", grant, 0);
    checkVal("rst_issue_done", done, 0);
    req = 3'b000;
    step();
    iRST_N = 1'b1;
    lastM = 2;
    step();
    serve(3'b111, 0, 0, 1, 4, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
